hazard_unit_sb: RTL and testbench
=================================

Name: hazard_unit_sb

Overview:
- Parametrised load-use hazard detection unit for the 5-stage MIPS pipeline, placed between the IF/ID and ID/EX registers.
- Adds a per-register scoreboard of load-latency countdowns, so loads whose memory latency exceeds one cycle stall dependent instructions for the correct number of cycles.
- Adds per-source "used" qualifiers and a branch-flush override.
- Drives the PC write enable, the IF/ID write enable and the ID/EX bubble-select mux.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- NUM_REGS, 32, architectural register count (2**REG_ADDR_W).
- LOAD_LAT, 1, stall cycles per load-use dependency (>=1). A value of 1 gives classic single-cycle load-use behaviour.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- if_idrs_i  input  REG_ADDR_W  rs of the instruction in ID.
- if_idrt_i  input  REG_ADDR_W  rt of the instruction in ID.
- rs_used_i  input  1  ID instruction reads rs.
- rt_used_i  input  1  ID instruction reads rt.
- id_ex_i  input  REG_ADDR_W  destination register of the instruction in EX.
- id_ex_memread_i  input  1  instruction in EX is a load.
- flush_i  input  1  IF/ID is being squashed this cycle (taken branch/jump).
- pc_o  output  1  PC write enable (1 = advance).
- if_id_o  output  1  IF/ID write enable (1 = load).
- mux8_o  output  1  bubble select (1 = zero ID/EX control signals).

Behaviour:
- State: cnt[r], r = 1..NUM_REGS-1, each CNT_W = max(1, clog2(LOAD_LAT)) bits. Register 0 has no counter and never hazards.
- Reset (rst_n_i = 0, asynchronous): all cnt cleared to 0. While in reset, outputs are forced to pc_o = 1, if_id_o = 1, mux8_o = 0.
- match_ex(x) = id_ex_memread_i & (id_ex_i == x) & (x != 0).
- busy(x) = (cnt[x] != 0).
- hazard = ~flush_i & ((rs_used_i & (match_ex(rs) | busy(rs))) | (rt_used_i & (match_ex(rt) | busy(rt)))).
- Outputs are combinational from the inputs and the current counters:
  - hazard = 1: pc_o = 0, if_id_o = 0, mux8_o = 1.
  - hazard = 0: pc_o = 1, if_id_o = 1, mux8_o = 0.
- Per-cycle counter update, for every register r:
  - If id_ex_memread_i & (id_ex_i == r) & (r != 0): cnt[r] <= LOAD_LAT-1 (load issue overrides decrement).
  - Else if cnt[r] != 0: cnt[r] <= cnt[r]-1.
  - Else cnt[r] holds 0 (saturating, no wrap).
- Latency: a consumer immediately behind a load stalls exactly LOAD_LAT cycles. The stall is released in the cycle where cnt reaches 0 and EX no longer holds the load.
- A second load to the same register restarts that register's countdown at LOAD_LAT-1.
- Loads to different registers count down independently.
- Both rs and rt pending: the stall lasts until the later of the two counters clears.
- flush_i = 1 suppresses stall outputs only. Counters keep updating, so a later dependent instruction still stalls correctly.
- Unused sources (used_i = 0) never cause a stall, even when the specifier matches.
- Reset asserted mid-stall clears the scoreboard immediately. After release, no residual stall.

Optional Feature:
- Macro HD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits, counting cycles with hazard = 1.
  - Cleared on reset; wraps modulo 2**32.
  - Does not increment while flush_i = 1.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package hd_pkg holds REG_ADDR_W and NUM_REGS defaults, the CNT_W computation function, and a stall-control struct {pc_we, ifid_we, bubble}.
- One natural sub-module: hd_ld_timer, a single register's countdown (load, decrement, busy flag), instantiated NUM_REGS-1 times via generate.

Test Plan:
- LOAD_LAT = 1: lw r5 in EX, ID add with rs = r5, rs_used = 1 -> exactly 1 stall cycle (pc_o = 0, if_id_o = 0, mux8_o = 1), then no stall.
- LOAD_LAT = 3: lw r5 at cycle 0, consumer of r5 held in ID -> stall cycles 0, 1, 2; pc_o = 1 at cycle 3.
- LOAD_LAT = 3: lw r5 at cycle 0, lw r6 at cycle 1, consumer uses rs = r5 and rt = r6 -> stall continues through cycle 3, released at cycle 4.
- lw r0, or lw r7 with rt = r7 but rt_used_i = 0 -> no stall.
- LOAD_LAT = 3: lw r5, flush_i = 1 in cycle 1 with ID using r5 -> no stall in cycle 1. A new ID instruction using r5 in cycle 2 stalls in cycle 2 only.
- LOAD_LAT = 3: rst_n_i pulsed low during the cycle-1 stall -> outputs immediately return to no-stall, and all counters read 0 after reset.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared types, defaults and the counter-width helper for the load-use hazard unit.
package hd_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned NUM_REGS_DEF   = 32;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic bubble;
    } stall_ctrl_t;

    localparam stall_ctrl_t CtrlRun   = '{pc_we: 1'b1, ifid_we: 1'b1, bubble: 1'b0};
    localparam stall_ctrl_t CtrlStall = '{pc_we: 1'b0, ifid_we: 1'b0, bubble: 1'b1};

    // Width of a countdown that must hold LOAD_LAT-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/hazard_unit_sb_ld_timer.sv
// Single-register load-latency countdown: reload on load issue, else saturating decrement.
module hd_ld_timer #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit_sb.sv
// Load-use hazard unit with per-register load-latency scoreboard and flush override.
// Optional stall-cycle counter output enabled by defining HD_PERF_CNT_EN.
module hazard_unit_sb
    import hd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] if_idrs_i,
    input  logic [REG_ADDR_W-1:0] if_idrt_i,
    input  logic                  rs_used_i,
    input  logic                  rt_used_i,
    input  logic [REG_ADDR_W-1:0] id_ex_i,
    input  logic                  id_ex_memread_i,
    input  logic                  flush_i,
`ifdef HD_PERF_CNT_EN
    output logic [31:0]           stall_cnt_o,
`endif
    output logic                  pc_o,
    output logic                  if_id_o,
    output logic                  mux8_o
);

    localparam int unsigned CNT_W = cnt_w(LOAD_LAT);

    logic [NUM_REGS-1:0] busy_vec;
    logic                match_rs, match_rt;
    logic                haz_rs, haz_rt, hazard;
    stall_ctrl_t         ctrl;

    // r0 is hardwired zero and never pending.
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
        localparam logic [REG_ADDR_W-1:0] RegIdx = REG_ADDR_W'(r);
        hd_ld_timer #(
            .LOAD_LAT (LOAD_LAT),
            .CNT_W    (CNT_W)
        ) u_timer (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .load_i  (id_ex_memread_i && (id_ex_i == RegIdx)),
            .busy_o  (busy_vec[r])
        );
    end

    assign match_rs = id_ex_memread_i && (id_ex_i == if_idrs_i) && (if_idrs_i != '0);
    assign match_rt = id_ex_memread_i && (id_ex_i == if_idrt_i) && (if_idrt_i != '0);
    assign haz_rs   = rs_used_i && (match_rs || busy_vec[if_idrs_i]);
    assign haz_rt   = rt_used_i && (match_rt || busy_vec[if_idrt_i]);
    assign hazard   = !flush_i && (haz_rs || haz_rt);

    always_comb begin
        ctrl = CtrlRun;
        if (rst_n_i && hazard) begin
            ctrl = CtrlStall;
        end
    end

    assign pc_o    = ctrl.pc_we;
    assign if_id_o = ctrl.ifid_we;
    assign mux8_o  = ctrl.bubble;

`ifdef HD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = hazard ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Scoreboard bench driving one stimulus stream into LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_hazard_unit_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, ex;
    logic       rs_used, rt_used, memread, flush;
    logic       pc1, ifid1, mux1, pc3, ifid3, mux3;
`ifdef HD_PERF_CNT_EN
    logic [31:0] scnt1, scnt3;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_cnt1 = 0;
    int exp_cnt3 = 0;
    logic [5:0] sb_q[$];

    always #5 clk = ~clk;

    hazard_unit_sb #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .if_idrs_i(rs), .if_idrt_i(rt),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .id_ex_i(ex),
        .id_ex_memread_i(memread), .flush_i(flush),
`ifdef HD_PERF_CNT_EN
        .stall_cnt_o(scnt1),
`endif
        .pc_o(pc1), .if_id_o(ifid1), .mux8_o(mux1)
    );

    hazard_unit_sb #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .if_idrs_i(rs), .if_idrt_i(rt),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .id_ex_i(ex),
        .id_ex_memread_i(memread), .flush_i(flush),
`ifdef HD_PERF_CNT_EN
        .stall_cnt_o(scnt3),
`endif
        .pc_o(pc3), .if_id_o(ifid3), .mux8_o(mux3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outs(input logic stall);
        return stall ? 3'b001 : 3'b110;
    endfunction

    // One pipeline cycle: drive, push expected, compare on the falling edge.
    task automatic step(input string tag, input logic [4:0] s, input logic su,
                        input logic [4:0] t, input logic tu, input logic [4:0] e,
                        input logic mr, input logic fl, input logic st1, input logic st3);
        logic [5:0] exp;
        rs = s; rs_used = su; rt = t; rt_used = tu; ex = e; memread = mr; flush = fl;
        sb_q.push_back({outs(st1), outs(st3)});
        if (st1) exp_cnt1++;
        if (st3) exp_cnt3++;
        @(negedge clk);
        exp = sb_q.pop_front();
        check({tag, "/lat1"}, {29'd0, pc1, ifid1, mux1}, {29'd0, exp[5:3]});
        check({tag, "/lat3"}, {29'd0, pc3, ifid3, mux3}, {29'd0, exp[2:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset forces no-stall even with a hazardous input pattern.
        rst_n = 1'b0; rs = 5'd5; rt = 5'd0; ex = 5'd5; memread = 1'b1;
        rs_used = 1'b1; rt_used = 1'b0; flush = 1'b0;
        #12;
        check("reset_out/lat1", {29'd0, pc1, ifid1, mux1}, 32'd6);
        check("reset_out/lat3", {29'd0, pc3, ifid3, mux3}, 32'd6);
        memread = 1'b0; rs_used = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(1);

        // Single load-use: 1 stall at lat 1, 3 stalls at lat 3.
        step("lu_c0", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        step("lu_c1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_c2", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_c3", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Two loads, consumer uses both: released when the later counter clears.
        step("two_c0", 5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        step("two_c1", 5'd5, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        step("two_c2", 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("two_c3", 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("two_c4", 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // r0 load and an unused matching source never stall.
        step("r0", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("r0_after", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("unused_rt", 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Flush hides the stall but the countdown keeps running.
        step("fl_c0", 5'd9, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fl_c1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fl_c2", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fl_c3", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // A second load to the same register restarts its countdown.
        step("rl_c0", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rl_c1", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rl_c2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rl_c3", 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rl_c4", 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rl_c5", 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

`ifdef HD_PERF_CNT_EN
        check("perf/lat1", scnt1, 32'(exp_cnt1));
        check("perf/lat3", scnt3, 32'(exp_cnt3));
`endif

        // Reset pulsed during the cycle-1 stall clears everything at once.
        step("rst_c0", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        step("rst_c1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid/lat3", {29'd0, pc3, ifid3, mux3}, 32'd6);
`ifdef HD_PERF_CNT_EN
        check("rst_mid/perf", scnt3, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rst_after", 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst_after2", 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
